alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//  Reservation station feeding the integer ALU in the Tomasulo core. Buffers dispatched
//  ALU ops until both operands are ready, snooping the CDB for renamed operands.
//  Issues at most one ready op per cycle to the ALU as opr1/opr2/op_L1/op_L2/rob_id.
// PARAMETERS
//  RS_SIZE    8  number of entries (power of 2, >=2)
//  ROB_ID_W   5  ROB tag width, matches [`ROB_WIDTH:0]
// PORTS
//  clk          in   1        clock, posedge
//  rst          in   1        async reset, active-low
//  flush        in   1        mispredict flush, synchronous
//  disp_valid   in   1        dispatch request this cycle
//  disp_op_L1   in   3        ALU major op (ADD_SUB..AND encoding)
//  disp_op_L2   in   1        ALU minor op (SUB / SRA select)
//  disp_rob_id  in   ROB_ID_W destination ROB tag
//  disp_vj      in   32       operand 1 value (valid when !disp_qj_busy)
//  disp_qj      in   ROB_ID_W operand 1 producer tag
//  disp_qj_busy in   1        operand 1 still pending
//  disp_vk      in   32       operand 2 value / immediate
//  disp_qk      in   ROB_ID_W operand 2 producer tag
//  disp_qk_busy in   1        operand 2 still pending
//  cdb_valid    in   1        CDB broadcast valid
//  cdb_rob_id   in   ROB_ID_W CDB tag
//  cdb_value    in   32       CDB result
//  rs_full      out  1        no free entry (from registered state)
//  alu_valid    out  1        issue valid to ALU
//  alu_opr1     out  32       issued operand 1
//  alu_opr2     out  32       issued operand 2
//  alu_op_L1    out  3        issued major op
//  alu_op_L2    out  1        issued minor op
//  alu_rob_id   out  ROB_ID_W issued ROB tag
// BEHAVIOUR
//  - Reset (rst=0, async): all entries invalid; alu_valid=0, all alu_* = 0; rs_full=0.
//  - Entry fields: busy, op_L1, op_L2, rob_id, vj, qj, qj_busy, vk, qk, qk_busy.
//  - rs_full = (all entries busy), combinational from registered busy bits only.
//  - Dispatch: if disp_valid && !rs_full && !flush, write lowest-index free entry.
//    disp_valid while rs_full: request dropped, no state change (dispatcher must not do this).
//  - Dispatch bypass: if disp_q*_busy && cdb_valid && cdb_rob_id==disp_q*, store
//    cdb_value and clear busy for that operand in the written entry.
//  - Wakeup: each cycle, every busy entry with q*_busy && tag match on CDB captures
//    cdb_value into v*, clears q*_busy. Both operands may wake in the same cycle.
//  - Ready = busy && !qj_busy && !qk_busy, evaluated on registered state; an op woken
//    in cycle N is issuable at earliest cycle N+1 (no CDB-to-issue combinational path).
//  - Issue: lowest-index ready entry selected; at posedge, alu_* registered from it,
//    alu_valid=1, entry freed. No ready entry -> alu_valid=0, alu_* hold last values.
//    Latency dispatch(ready operands)->alu_valid = 2 edges (write, then issue).
//  - Simultaneous issue + dispatch: slot freed by issue is NOT reusable same cycle;
//    rs_full reflects pre-edge state. Dispatch may use any other free slot.
//  - flush: at posedge, all entries invalid, alu_valid=0; dispatch same cycle ignored.
//    Flush has priority over dispatch, wakeup and issue.
//  - Reset mid-operation: all state cleared immediately, no issue after reset release
//    until new dispatch.
//  - No ALU backpressure: ALU accepts one op per cycle unconditionally.
// TESTING
//  1 Dispatch ADD vj=5 vk=7 both ready, cycle 0 -> cycle 2 alu_valid=1, opr1=5, opr2=7,
//    op_L1=000, rob_id as dispatched; cycle 3 alu_valid=0.
//  2 Dispatch SUB qj=3 busy, vk=1; CDB tag 3 value 10 at cycle 4 -> issue at cycle 5
//    with opr1=10, opr2=1, op_L2=1; no issue before.
//  3 Dispatch with qj=6 busy while CDB broadcasts tag 6 value 0xFFFF_FFFF same cycle ->
//    operand captured; issue next cycle with opr1=0xFFFF_FFFF.
//  4 Fill all 8 entries with pending ops -> rs_full=1; 9th disp_valid dropped;
//    wake entry 2 -> issues, rs_full=0 the cycle after freeing.
//  5 Entries 1 and 4 ready same cycle -> entry 1 issues first, entry 4 next cycle.
//  6 flush with 3 busy entries and concurrent dispatch -> next cycle all free,
//    alu_valid=0, rs_full=0; async rst low mid-run -> alu_valid=0 immediately.

Source files
------------

// File: rtl/alu_rs_if.sv
// Bus between the dispatcher/CDB side and the ALU reservation station.
// Handshake: a dispatch is taken on a rising clk when disp_valid=1, rs_full=0 and
// flush=0; alu_valid is a one-cycle issue pulse with no ready (the ALU always accepts).
interface alu_rs_if #(
   parameter int ROB_ID_W = 5
);
   logic                disp_valid;
   logic [2:0]          disp_op_L1;
   logic                disp_op_L2;
   logic [ROB_ID_W-1:0] disp_rob_id;
   logic [31:0]         disp_vj;
   logic [ROB_ID_W-1:0] disp_qj;
   logic                disp_qj_busy;
   logic [31:0]         disp_vk;
   logic [ROB_ID_W-1:0] disp_qk;
   logic                disp_qk_busy;
   logic                cdb_valid;
   logic [ROB_ID_W-1:0] cdb_rob_id;
   logic [31:0]         cdb_value;
   logic                rs_full;
   logic                alu_valid;
   logic [31:0]         alu_opr1;
   logic [31:0]         alu_opr2;
   logic [2:0]          alu_op_L1;
   logic                alu_op_L2;
   logic [ROB_ID_W-1:0] alu_rob_id;

   modport master (
      output disp_valid, disp_op_L1, disp_op_L2, disp_rob_id,
      output disp_vj, disp_qj, disp_qj_busy, disp_vk, disp_qk, disp_qk_busy,
      output cdb_valid, cdb_rob_id, cdb_value,
      input  rs_full, alu_valid, alu_opr1, alu_opr2, alu_op_L1, alu_op_L2, alu_rob_id
   );

   modport slave (
      input  disp_valid, disp_op_L1, disp_op_L2, disp_rob_id,
      input  disp_vj, disp_qj, disp_qj_busy, disp_vk, disp_qk, disp_qk_busy,
      input  cdb_valid, cdb_rob_id, cdb_value,
      output rs_full, alu_valid, alu_opr1, alu_opr2, alu_op_L1, alu_op_L2, alu_rob_id
   );
endinterface

// File: rtl/alu_rs.sv
// Integer ALU reservation station: holds dispatched ops until both operands are
// captured (at dispatch or from the CDB), then issues the lowest ready entry per cycle.
module alu_rs #(
   parameter int RS_SIZE  = 8,
   parameter int ROB_ID_W = 5
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   alu_rs_if.slave  bus
);
   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0]  r_busy;
   logic [RS_SIZE-1:0]  r_qj_busy;
   logic [RS_SIZE-1:0]  r_qk_busy;
   logic [2:0]          r_op_l1 [RS_SIZE];
   logic                r_op_l2 [RS_SIZE];
   logic [ROB_ID_W-1:0] r_rob_id [RS_SIZE];
   logic [31:0]         r_vj [RS_SIZE];
   logic [ROB_ID_W-1:0] r_qj [RS_SIZE];
   logic [31:0]         r_vk [RS_SIZE];
   logic [ROB_ID_W-1:0] r_qk [RS_SIZE];

   logic                r_alu_valid;
   logic [31:0]         r_alu_opr1;
   logic [31:0]         r_alu_opr2;
   logic [2:0]          r_alu_op_l1;
   logic                r_alu_op_l2;
   logic [ROB_ID_W-1:0] r_alu_rob_id;

   logic [RS_SIZE-1:0]  w_ready;
   logic                w_full;
   logic                w_issue_any;
   logic [IDX_W-1:0]    w_issue_sel;
   logic [IDX_W-1:0]    w_free_sel;
   logic                w_disp_we;
   logic                w_disp_j_hit;
   logic                w_disp_k_hit;

   // Ready and free-slot selection look only at registered state, so a slot freed by
   // this cycle's issue cannot be reused until the next cycle.
   always_comb begin
      w_ready     = r_busy & ~r_qj_busy & ~r_qk_busy;
      w_full      = &r_busy;
      w_issue_any = |w_ready;
      w_issue_sel = '0;
      w_free_sel  = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (w_ready[i]) w_issue_sel = IDX_W'(i);
         if (!r_busy[i]) w_free_sel = IDX_W'(i);
      end
   end

   assign w_disp_we    = bus.disp_valid && !w_full && !flush;
   assign w_disp_j_hit = bus.disp_qj_busy && bus.cdb_valid && (bus.cdb_rob_id == bus.disp_qj);
   assign w_disp_k_hit = bus.disp_qk_busy && bus.cdb_valid && (bus.cdb_rob_id == bus.disp_qk);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy    <= '0;
         r_qj_busy <= '0;
         r_qk_busy <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            r_op_l1[i]  <= '0;
            r_op_l2[i]  <= 1'b0;
            r_rob_id[i] <= '0;
            r_vj[i]     <= '0;
            r_qj[i]     <= '0;
            r_vk[i]     <= '0;
            r_qk[i]     <= '0;
         end
      end else if (flush) begin
         r_busy    <= '0;
         r_qj_busy <= '0;
         r_qk_busy <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (r_busy[i] && r_qj_busy[i] && bus.cdb_valid && (r_qj[i] == bus.cdb_rob_id)) begin
               r_vj[i]      <= bus.cdb_value;
               r_qj_busy[i] <= 1'b0;
            end
            if (r_busy[i] && r_qk_busy[i] && bus.cdb_valid && (r_qk[i] == bus.cdb_rob_id)) begin
               r_vk[i]      <= bus.cdb_value;
               r_qk_busy[i] <= 1'b0;
            end
            if (w_issue_any && (w_issue_sel == IDX_W'(i))) begin
               r_busy[i] <= 1'b0;
            end
            // The dispatch slot is never busy, so it cannot collide with wakeup or issue.
            if (w_disp_we && (w_free_sel == IDX_W'(i))) begin
               r_busy[i]    <= 1'b1;
               r_op_l1[i]   <= bus.disp_op_L1;
               r_op_l2[i]   <= bus.disp_op_L2;
               r_rob_id[i]  <= bus.disp_rob_id;
               r_qj[i]      <= bus.disp_qj;
               r_qk[i]      <= bus.disp_qk;
               r_vj[i]      <= w_disp_j_hit ? bus.cdb_value : bus.disp_vj;
               r_vk[i]      <= w_disp_k_hit ? bus.cdb_value : bus.disp_vk;
               r_qj_busy[i] <= bus.disp_qj_busy && !w_disp_j_hit;
               r_qk_busy[i] <= bus.disp_qk_busy && !w_disp_k_hit;
            end
         end
      end
   end

   // Issue register: payload holds its last value when nothing issues.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_alu_valid  <= 1'b0;
         r_alu_opr1   <= '0;
         r_alu_opr2   <= '0;
         r_alu_op_l1  <= '0;
         r_alu_op_l2  <= 1'b0;
         r_alu_rob_id <= '0;
      end else if (flush) begin
         r_alu_valid <= 1'b0;
      end else begin
         r_alu_valid <= w_issue_any;
         if (w_issue_any) begin
            r_alu_opr1   <= r_vj[w_issue_sel];
            r_alu_opr2   <= r_vk[w_issue_sel];
            r_alu_op_l1  <= r_op_l1[w_issue_sel];
            r_alu_op_l2  <= r_op_l2[w_issue_sel];
            r_alu_rob_id <= r_rob_id[w_issue_sel];
         end
      end
   end

   assign bus.rs_full    = w_full;
   assign bus.alu_valid  = r_alu_valid;
   assign bus.alu_opr1   = r_alu_opr1;
   assign bus.alu_opr2   = r_alu_opr2;
   assign bus.alu_op_L1  = r_alu_op_l1;
   assign bus.alu_op_L2  = r_alu_op_l2;
   assign bus.alu_rob_id = r_alu_rob_id;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: dispatch, CDB wakeup/bypass, full handling, issue order,
// flush and asynchronous reset.
module tb_alu_rs;
   logic clk;
   logic rst;
   logic flush;
   int   checks;
   int   failures;

   alu_rs_if #(.ROB_ID_W(5)) bus ();

   alu_rs #(.RS_SIZE(8), .ROB_ID_W(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.disp_valid   = 1'b0;
      bus.disp_op_L1   = '0;
      bus.disp_op_L2   = 1'b0;
      bus.disp_rob_id  = '0;
      bus.disp_vj      = '0;
      bus.disp_qj      = '0;
      bus.disp_qj_busy = 1'b0;
      bus.disp_vk      = '0;
      bus.disp_qk      = '0;
      bus.disp_qk_busy = 1'b0;
      bus.cdb_valid    = 1'b0;
      bus.cdb_rob_id   = '0;
      bus.cdb_value    = '0;
      flush            = 1'b0;
   endtask

   task automatic drive_disp(input logic [2:0] op1, input logic op2, input logic [4:0] rob,
                             input logic [31:0] vj, input logic [4:0] qj, input logic qjb,
                             input logic [31:0] vk, input logic [4:0] qk, input logic qkb);
      bus.disp_valid   = 1'b1;
      bus.disp_op_L1   = op1;
      bus.disp_op_L2   = op2;
      bus.disp_rob_id  = rob;
      bus.disp_vj      = vj;
      bus.disp_qj      = qj;
      bus.disp_qj_busy = qjb;
      bus.disp_vk      = vk;
      bus.disp_qk      = qk;
      bus.disp_qk_busy = qkb;
   endtask

   task automatic drive_cdb(input logic [4:0] tag, input logic [31:0] val);
      bus.cdb_valid  = 1'b1;
      bus.cdb_rob_id = tag;
      bus.cdb_value  = val;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      repeat (2) step();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0h want 0", bus.alu_valid); end
      checks++; if (bus.alu_opr1 !== 32'h0 || bus.alu_opr2 !== 32'h0) begin failures++; $display("FAIL reset_opr: got %0h/%0h want 0/0", bus.alu_opr1, bus.alu_opr2); end
      checks++; if (bus.alu_op_L1 !== 3'h0 || bus.alu_op_L2 !== 1'b0 || bus.alu_rob_id !== 5'h0) begin failures++; $display("FAIL reset_op: got %0h/%0h/%0h want 0/0/0", bus.alu_op_L1, bus.alu_op_L2, bus.alu_rob_id); end
      checks++; if (bus.rs_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %0h want 0", bus.rs_full); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_ready_dispatch();
      drive_disp(3'b000, 1'b0, 5'd5, 32'd5, 5'd0, 1'b0, 32'd7, 5'd0, 1'b0);
      step();
      clear_inputs();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL add_early: got %0h want 0", bus.alu_valid); end
      step();
      checks++; if (bus.alu_valid !== 1'b1) begin failures++; $display("FAIL add_valid: got %0h want 1", bus.alu_valid); end
      checks++; if (bus.alu_opr1 !== 32'd5 || bus.alu_opr2 !== 32'd7) begin failures++; $display("FAIL add_opr: got %0h/%0h want 5/7", bus.alu_opr1, bus.alu_opr2); end
      checks++; if (bus.alu_op_L1 !== 3'b000 || bus.alu_rob_id !== 5'd5) begin failures++; $display("FAIL add_op: got %0h/%0h want 0/5", bus.alu_op_L1, bus.alu_rob_id); end
      step();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL add_after: got %0h want 0", bus.alu_valid); end
      checks++; if (bus.alu_opr1 !== 32'd5) begin failures++; $display("FAIL add_hold: got %0h want 5", bus.alu_opr1); end
   endtask

   task automatic test_wakeup();
      drive_disp(3'b000, 1'b1, 5'd2, 32'hDEAD, 5'd3, 1'b1, 32'd1, 5'd0, 1'b0);
      step();
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL sub_early%0d: got %0h want 0", i, bus.alu_valid); end
      end
      drive_cdb(5'd3, 32'd10);
      step();
      clear_inputs();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL sub_wake_edge: got %0h want 0", bus.alu_valid); end
      step();
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 5'd2) begin failures++; $display("FAIL sub_issue: got %0h/%0h want 1/2", bus.alu_valid, bus.alu_rob_id); end
      checks++; if (bus.alu_opr1 !== 32'd10 || bus.alu_opr2 !== 32'd1 || bus.alu_op_L2 !== 1'b1) begin failures++; $display("FAIL sub_data: got %0h/%0h/%0h want a/1/1", bus.alu_opr1, bus.alu_opr2, bus.alu_op_L2); end
      step();
   endtask

   task automatic test_bypass();
      drive_disp(3'b001, 1'b0, 5'd8, 32'h0, 5'd6, 1'b1, 32'd9, 5'd0, 1'b0);
      drive_cdb(5'd6, 32'hFFFF_FFFF);
      step();
      clear_inputs();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL byp_early: got %0h want 0", bus.alu_valid); end
      step();
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 5'd8) begin failures++; $display("FAIL byp_issue: got %0h/%0h want 1/8", bus.alu_valid, bus.alu_rob_id); end
      checks++; if (bus.alu_opr1 !== 32'hFFFF_FFFF || bus.alu_opr2 !== 32'd9) begin failures++; $display("FAIL byp_data: got %0h/%0h want ffffffff/9", bus.alu_opr1, bus.alu_opr2); end
      step();
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) begin
         drive_disp(3'b010, 1'b0, 5'(i), 32'h0, 5'(10 + i), 1'b1, 32'h100 + 32'(i), 5'd0, 1'b0);
         step();
         if (i == 6) begin
            checks++; if (bus.rs_full !== 1'b0) begin failures++; $display("FAIL full_seven: got %0h want 0", bus.rs_full); end
         end
      end
      clear_inputs();
      checks++; if (bus.rs_full !== 1'b1) begin failures++; $display("FAIL full_eight: got %0h want 1", bus.rs_full); end
      drive_disp(3'b000, 1'b0, 5'd20, 32'hAA, 5'd0, 1'b0, 32'hBB, 5'd0, 1'b0);
      step();
      clear_inputs();
      step();
      checks++; if (bus.alu_valid !== 1'b0 || bus.rs_full !== 1'b1) begin failures++; $display("FAIL full_drop: got %0h/%0h want 0/1", bus.alu_valid, bus.rs_full); end
      drive_cdb(5'd12, 32'h22);
      step();
      clear_inputs();
      checks++; if (bus.alu_valid !== 1'b0 || bus.rs_full !== 1'b1) begin failures++; $display("FAIL full_wake: got %0h/%0h want 0/1", bus.alu_valid, bus.rs_full); end
      drive_disp(3'b000, 1'b0, 5'd21, 32'hCC, 5'd0, 1'b0, 32'hDD, 5'd0, 1'b0);
      step();
      clear_inputs();
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 5'd2) begin failures++; $display("FAIL full_issue: got %0h/%0h want 1/2", bus.alu_valid, bus.alu_rob_id); end
      checks++; if (bus.alu_opr1 !== 32'h22 || bus.alu_opr2 !== 32'h102) begin failures++; $display("FAIL full_data: got %0h/%0h want 22/102", bus.alu_opr1, bus.alu_opr2); end
      checks++; if (bus.rs_full !== 1'b0) begin failures++; $display("FAIL full_freed: got %0h want 0", bus.rs_full); end
      step();
      checks++; if (bus.alu_valid !== 1'b0 || bus.rs_full !== 1'b0) begin failures++; $display("FAIL full_noreuse: got %0h/%0h want 0/0", bus.alu_valid, bus.rs_full); end
      do_flush();
   endtask

   task automatic test_priority();
      logic [4:0] tags [5];
      tags[0] = 5'd20; tags[1] = 5'd21; tags[2] = 5'd22; tags[3] = 5'd23; tags[4] = 5'd21;
      for (int i = 0; i < 5; i++) begin
         drive_disp(3'b011, 1'b0, 5'(i), 32'h0, tags[i], 1'b1, 32'h200 + 32'(i), 5'd0, 1'b0);
         step();
      end
      clear_inputs();
      drive_cdb(5'd21, 32'h11);
      step();
      clear_inputs();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL prio_early: got %0h want 0", bus.alu_valid); end
      step();
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 5'd1 || bus.alu_opr2 !== 32'h201) begin failures++; $display("FAIL prio_first: got %0h/%0h/%0h want 1/1/201", bus.alu_valid, bus.alu_rob_id, bus.alu_opr2); end
      checks++; if (bus.alu_opr1 !== 32'h11) begin failures++; $display("FAIL prio_opr1: got %0h want 11", bus.alu_opr1); end
      step();
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 5'd4 || bus.alu_opr2 !== 32'h204) begin failures++; $display("FAIL prio_second: got %0h/%0h/%0h want 1/4/204", bus.alu_valid, bus.alu_rob_id, bus.alu_opr2); end
      step();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL prio_done: got %0h want 0", bus.alu_valid); end
      do_flush();
   endtask

   task automatic test_back_to_back();
      drive_disp(3'b111, 1'b0, 5'd1, 32'd1, 5'd0, 1'b0, 32'd2, 5'd0, 1'b0);
      step();
      drive_disp(3'b111, 1'b0, 5'd2, 32'd2, 5'd0, 1'b0, 32'd4, 5'd0, 1'b0);
      step();
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 5'd1 || bus.alu_opr2 !== 32'd2) begin failures++; $display("FAIL b2b_1: got %0h/%0h/%0h want 1/1/2", bus.alu_valid, bus.alu_rob_id, bus.alu_opr2); end
      drive_disp(3'b111, 1'b0, 5'd3, 32'd3, 5'd0, 1'b0, 32'd6, 5'd0, 1'b0);
      step();
      clear_inputs();
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 5'd2 || bus.alu_opr1 !== 32'd2) begin failures++; $display("FAIL b2b_2: got %0h/%0h/%0h want 1/2/2", bus.alu_valid, bus.alu_rob_id, bus.alu_opr1); end
      step();
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 5'd3 || bus.alu_op_L1 !== 3'b111) begin failures++; $display("FAIL b2b_3: got %0h/%0h/%0h want 1/3/7", bus.alu_valid, bus.alu_rob_id, bus.alu_op_L1); end
      step();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL b2b_end: got %0h want 0", bus.alu_valid); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive_disp(3'b100, 1'b0, 5'(i), 32'h0, 5'(25 + i), 1'b1, 32'h0, 5'd0, 1'b0);
         step();
      end
      clear_inputs();
      flush = 1'b1;
      drive_disp(3'b000, 1'b0, 5'd9, 32'h9, 5'd0, 1'b0, 32'h9, 5'd0, 1'b0);
      step();
      clear_inputs();
      checks++; if (bus.alu_valid !== 1'b0 || bus.rs_full !== 1'b0) begin failures++; $display("FAIL flush_state: got %0h/%0h want 0/0", bus.alu_valid, bus.rs_full); end
      drive_cdb(5'd25, 32'h1);
      step();
      clear_inputs();
      step();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL flush_gone: got %0h want 0", bus.alu_valid); end
      drive_disp(3'b000, 1'b0, 5'd7, 32'h7, 5'd0, 1'b0, 32'h7, 5'd0, 1'b0);
      step();
      clear_inputs();
      do_flush();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL flush_issue: got %0h want 0", bus.alu_valid); end
      step();
      checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL flush_after: got %0h want 0", bus.alu_valid); end
   endtask

   task automatic test_async_reset();
      drive_disp(3'b101, 1'b1, 5'd3, 32'h33, 5'd0, 1'b0, 32'h44, 5'd0, 1'b0);
      step();
      clear_inputs();
      drive_disp(3'b000, 1'b0, 5'd4, 32'h0, 5'd30, 1'b1, 32'h0, 5'd0, 1'b0);
      step();
      clear_inputs();
      checks++; if (bus.alu_valid !== 1'b1 || bus.alu_opr1 !== 32'h33) begin failures++; $display("FAIL arst_pre: got %0h/%0h want 1/33", bus.alu_valid, bus.alu_opr1); end
      #2 rst = 1'b0;
      #1;
      checks++; if (bus.alu_valid !== 1'b0 || bus.alu_opr1 !== 32'h0 || bus.alu_rob_id !== 5'h0) begin failures++; $display("FAIL arst_now: got %0h/%0h/%0h want 0/0/0", bus.alu_valid, bus.alu_opr1, bus.alu_rob_id); end
      #2 rst = 1'b1;
      drive_cdb(5'd30, 32'h5);
      step();
      clear_inputs();
      step();
      checks++; if (bus.alu_valid !== 1'b0 || bus.rs_full !== 1'b0) begin failures++; $display("FAIL arst_after: got %0h/%0h want 0/0", bus.alu_valid, bus.rs_full); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_ready_dispatch();
      test_wakeup();
      test_bypass();
      test_full();
      test_priority();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
